melody_sequencer: RTL
=====================

// Module: melody_sequencer
// PURPOSE
//  Plays a fixed note list one note after another as a square-wave PCM sample stream.
//  Sits upstream of the audio mixer. Its sample output is added to the line-in
//  audio and passed to Audio_Controller left/right out.
//  It replaces the parallel, always-on tone instances with a timed sequence of
//  notes and rests.
// PARAMETERS
//  NUM_NOTES  5            entries in the note ROM (1..16)
//  AMPLITUDE  32'd10000000 square-wave peak; the output swings between +AMPLITUDE and -AMPLITUDE
//  TICK_DIV   50000        CLOCK_50 cycles per duration tick (1 ms at 50 MHz)
//  GAP_TICKS  20           silent ticks inserted after every note (0 = no gap)
// PORTS
//  CLOCK_50    in   1   system clock, 50 MHz
//  reset       in   1   synchronous, active-high
//  start       in   1   one-cycle pulse; begins playback at note 0 (acted on only in IDLE)
//  stop        in   1   level; aborts playback; has priority over start
//  loop        in   1   1 = after the last gap, restart at note 0; 0 = return to IDLE
//  sample      out  32  signed PCM sample, registered
//  note_index  out  4   index of the current ROM entry
//  playing     out  1   1 in every state except IDLE
//  note_done   out  1   one-cycle pulse on the last cycle of each PLAY interval
// BEHAVIOUR
//  Reset values: sample=0, note_index=0, playing=0, note_done=0, FSM=IDLE, all counters=0.
//  ROM entry: {half_period[20:0], dur_ticks[11:0]}.
//   - half_period=0 is a rest: output 0 for the whole duration.
//   - Default contents: C4 95556, D5 42566, E5 37922, D5 42566, C5 47778; 250 ticks each.
//  FSM transitions:
//   - IDLE: start & !stop -> LOAD with note_index=0.
//   - LOAD, 1 cycle: registers the ROM entry and clears the tick prescaler, tick counter,
//     half-period counter and phase (phase=0 means positive).
//     Goes to PLAY, or to GAP if dur_ticks=0.
//   - PLAY: lasts exactly dur_ticks*TICK_DIV cycles. note_done pulses on the final cycle.
//     Then goes to GAP, or skips GAP if GAP_TICKS=0.
//   - GAP: lasts exactly GAP_TICKS*TICK_DIV cycles with sample=0.
//   - End of a note: if note_index<NUM_NOTES-1, increment the index and go to LOAD.
//     Otherwise go to LOAD with index 0 if loop=1 (sampled on that cycle), else go to IDLE.
//   - stop=1 in any state: IDLE on the next edge; sample=0 and note_index=0 on that same edge.
//  Tone generation (PLAY only):
//   - half_cnt counts 0..half_period-1.
//   - At half_period-1, phase toggles and half_cnt returns to 0, so the waveform period is
//     2*half_period cycles.
//  sample register:
//   - In PLAY: +AMPLITUDE when phase=0, -AMPLITUDE when phase=1, 0 for a rest.
//   - In all other states: 0.
//   - It is a registered copy, so it lags the FSM state by 1 cycle.
//   - The first nonzero sample appears 2 cycles after start: 1 cycle in LOAD, then the register.
//  Widths:
//   - tick counter is 12 bits; prescaler is $clog2(TICK_DIV) bits; half_cnt is 21 bits.
//   - -AMPLITUDE is the 32-bit two's complement of AMPLITUDE.
//  Boundary cases:
//   - start while playing is ignored.
//   - start and stop in the same cycle: stop wins.
//   - reset mid-note returns every output to its reset value on the next edge.
//   - NUM_NOTES=1 with loop=1 replays the same note indefinitely.
// STRUCTURE
//  Shared package: note half-period constants (C4..C6), the ROM entry field widths, and
//  the FSM state encoding (IDLE, LOAD, PLAY, GAP).
//  Sub-module note_rom: combinational case on the 4-bit index returning the
//  {half_period, dur_ticks} entry; out-of-range indices return 0.
//  The top level holds the FSM, the prescaler, the tick counter, the half-period
//  counter and the sample register.
// TESTING (bench uses TICK_DIV=4, GAP_TICKS=2, test ROM half_period=3, dur_ticks=5)
//  1. reset held 3 cycles, then released with start=0 -> sample=0, playing=0, note_index=0 indefinitely.
//  2. start pulse -> sample +A at cycle 2; toggles every 3 cycles; note_done after 20 PLAY cycles;
//     then 8 cycles of 0; note_index goes to 1.
//  3. loop=0, full sequence -> after the last gap, playing=0 and FSM=IDLE; the total cycle
//     count equals NUM_NOTES*(1+20+8).
//  4. loop=1 -> after the last note, note_index wraps to 0 and playback continues without passing IDLE.
//  5. stop asserted mid-PLAY, and start+stop asserted together in IDLE
//     -> IDLE next cycle, sample=0 both times; the start is ignored.
//  6. rest entry (half_period=0), then dur_ticks=0 entry -> sample=0 for 20 cycles;
//     the zero-duration entry goes LOAD->GAP with no note_done pulse.

Source files
------------

// File: rtl/melody_sequencer_pkg.sv
// rtl/melody_sequencer_pkg.sv - note constants, ROM entry layout and FSM encoding for melody_sequencer
package melody_sequencer_pkg;

  localparam int HP_W      = 21;
  localparam int DUR_W     = 12;
  localparam int ROM_W     = HP_W + DUR_W;
  localparam int ROM_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [HP_W-1:0]  half_period;
    logic [DUR_W-1:0] dur_ticks;
  } rom_entry_t;

  // Half periods in 50 MHz cycles: 50e6 / (2 * f_note)
  localparam logic [HP_W-1:0] NOTE_C4 = 21'd95556;
  localparam logic [HP_W-1:0] NOTE_D4 = 21'd85131;
  localparam logic [HP_W-1:0] NOTE_E4 = 21'd75843;
  localparam logic [HP_W-1:0] NOTE_F4 = 21'd71586;
  localparam logic [HP_W-1:0] NOTE_G4 = 21'd63776;
  localparam logic [HP_W-1:0] NOTE_A4 = 21'd56818;
  localparam logic [HP_W-1:0] NOTE_B4 = 21'd50619;
  localparam logic [HP_W-1:0] NOTE_C5 = 21'd47778;
  localparam logic [HP_W-1:0] NOTE_D5 = 21'd42566;
  localparam logic [HP_W-1:0] NOTE_E5 = 21'd37922;
  localparam logic [HP_W-1:0] NOTE_F5 = 21'd35793;
  localparam logic [HP_W-1:0] NOTE_G5 = 21'd31888;
  localparam logic [HP_W-1:0] NOTE_A5 = 21'd28409;
  localparam logic [HP_W-1:0] NOTE_B5 = 21'd25310;
  localparam logic [HP_W-1:0] NOTE_C6 = 21'd23889;

  localparam logic [DUR_W-1:0] DUR_DEFAULT = 12'd250;

  // Entry 0 sits in the least significant slice
  localparam logic [ROM_W*ROM_DEPTH-1:0] DEFAULT_ROM = {
    {11{33'd0}},
    {NOTE_C5, DUR_DEFAULT},
    {NOTE_D5, DUR_DEFAULT},
    {NOTE_E5, DUR_DEFAULT},
    {NOTE_D5, DUR_DEFAULT},
    {NOTE_C4, DUR_DEFAULT}
  };

endpackage

// File: rtl/melody_sequencer_note_rom.sv
// rtl/melody_sequencer_note_rom.sv - combinational note table lookup; indices past NUM_NOTES read as 0
module melody_sequencer_note_rom
  import melody_sequencer_pkg::*;
#(
  parameter int unsigned                   NUM_NOTES = 5,
  parameter logic [ROM_W*ROM_DEPTH-1:0]    ROM_TABLE = DEFAULT_ROM
) (
  input  logic [3:0]  index_i,
  output rom_entry_t  entry_o
);

  always_comb begin
    entry_o = '0;
    if ({28'd0, index_i} < NUM_NOTES) begin
      case (index_i)
        4'd0:  entry_o = ROM_TABLE[ 0*ROM_W +: ROM_W];
        4'd1:  entry_o = ROM_TABLE[ 1*ROM_W +: ROM_W];
        4'd2:  entry_o = ROM_TABLE[ 2*ROM_W +: ROM_W];
        4'd3:  entry_o = ROM_TABLE[ 3*ROM_W +: ROM_W];
        4'd4:  entry_o = ROM_TABLE[ 4*ROM_W +: ROM_W];
        4'd5:  entry_o = ROM_TABLE[ 5*ROM_W +: ROM_W];
        4'd6:  entry_o = ROM_TABLE[ 6*ROM_W +: ROM_W];
        4'd7:  entry_o = ROM_TABLE[ 7*ROM_W +: ROM_W];
        4'd8:  entry_o = ROM_TABLE[ 8*ROM_W +: ROM_W];
        4'd9:  entry_o = ROM_TABLE[ 9*ROM_W +: ROM_W];
        4'd10: entry_o = ROM_TABLE[10*ROM_W +: ROM_W];
        4'd11: entry_o = ROM_TABLE[11*ROM_W +: ROM_W];
        4'd12: entry_o = ROM_TABLE[12*ROM_W +: ROM_W];
        4'd13: entry_o = ROM_TABLE[13*ROM_W +: ROM_W];
        4'd14: entry_o = ROM_TABLE[14*ROM_W +: ROM_W];
        default: entry_o = ROM_TABLE[15*ROM_W +: ROM_W];
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - timed note/rest sequencer producing a square-wave PCM sample stream
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int unsigned                NUM_NOTES = 5,
  parameter logic [31:0]                AMPLITUDE = 32'd10000000,
  parameter int unsigned                TICK_DIV  = 50000,
  parameter int unsigned                GAP_TICKS = 20,
  parameter logic [ROM_W*ROM_DEPTH-1:0] ROM_TABLE = DEFAULT_ROM
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  output logic signed [31:0] sample,
  output logic [3:0]         note_index,
  output logic               playing,
  output logic               note_done
);

  localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LAST   = DUR_W'(GAP_TICKS - 1);
  localparam logic [3:0]       LAST_INDEX = 4'(NUM_NOTES - 1);

  state_e            state_q, state_d;
  rom_entry_t        entry_q, entry_d, rom_entry;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DUR_W-1:0]  tick_q, tick_d;
  logic [HP_W-1:0]   half_cnt_q, half_cnt_d;
  logic              phase_q, phase_d;
  logic [3:0]        index_q, index_d;
  logic [31:0]       sample_q, sample_d;
  logic              tick_end, play_last, gap_last, note_end;

  melody_sequencer_note_rom #(
    .NUM_NOTES (NUM_NOTES),
    .ROM_TABLE (ROM_TABLE)
  ) u_note_rom (
    .index_i (index_q),
    .entry_o (rom_entry)
  );

  assign tick_end  = (presc_q == PRESC_LAST);
  assign play_last = (state_q == ST_PLAY) && tick_end
                     && (tick_q == entry_q.dur_ticks - DUR_W'(1));
  assign gap_last  = (state_q == ST_GAP) && tick_end && (tick_q == GAP_LAST);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    index_d    = index_q;
    sample_d   = '0;
    note_end   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          index_d = '0;
        end
      end
      ST_LOAD: begin
        entry_d    = rom_entry;
        presc_d    = '0;
        tick_d     = '0;
        half_cnt_d = '0;
        phase_d    = 1'b0;
        if (rom_entry.dur_ticks != '0) state_d = ST_PLAY;
        else if (GAP_TICKS != 0)       state_d = ST_GAP;
        else                           note_end = 1'b1;
      end
      ST_PLAY: begin
        presc_d = tick_end ? '0 : presc_q + PW'(1);
        tick_d  = tick_end ? tick_q + DUR_W'(1) : tick_q;
        if (entry_q.half_period != '0)
          sample_d = phase_q ? -AMPLITUDE : AMPLITUDE;
        if (half_cnt_q == entry_q.half_period - HP_W'(1)) begin
          half_cnt_d = '0;
          phase_d    = ~phase_q;
        end else begin
          half_cnt_d = half_cnt_q + HP_W'(1);
        end
        if (play_last) begin
          presc_d = '0;
          tick_d  = '0;
          if (GAP_TICKS != 0) state_d = ST_GAP;
          else                note_end = 1'b1;
        end
      end
      ST_GAP: begin
        presc_d = tick_end ? '0 : presc_q + PW'(1);
        tick_d  = tick_end ? tick_q + DUR_W'(1) : tick_q;
        if (gap_last) note_end = 1'b1;
      end
    endcase

    // Advance to the next entry, wrap on loop, or fall back to IDLE
    if (note_end) begin
      state_d = ST_LOAD;
      if (index_q < LAST_INDEX) begin
        index_d = index_q + 4'd1;
      end else begin
        index_d = '0;
        if (!loop) state_d = ST_IDLE;
      end
    end

    if (stop) begin
      state_d  = ST_IDLE;
      index_d  = '0;
      sample_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      entry_q    <= '0;
      presc_q    <= '0;
      tick_q     <= '0;
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      index_q    <= '0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
      index_q    <= index_d;
      sample_q   <= sample_d;
    end
  end

  assign sample     = $signed(sample_q);
  assign note_index = index_q;
  assign playing    = (state_q != ST_IDLE);
  assign note_done  = play_last;

endmodule
